rr_select_2bit: RTL and testbench

//  4-channel round-robin arbiter that produces the 2-bit select {a1,a0} driving the
//  2-to-4 decoder stage directly downstream. Requesters raise req[i]. The arbiter grants
//  one channel, holds the select stable until release, then rotates priority.
//  The decoder's one-hot outputs form the per-channel enables. gnt_valid gates them.

---
 rtl/rr_select_2bit_pkg.sv | 16 +
 rtl/rr_pick4.sv | 31 +++
 rtl/rr_select_2bit.sv | 105 ++++++++++
 tb/tb_rr_select_2bit.sv | 195 +++++++++++++++++++
 4 files changed

// File: rtl/rr_select_2bit_pkg.sv
// rr_pkg: shared types and constants for the 4-channel round-robin select block.
//   sel_t    - 2-bit channel select driven to the downstream 2-to-4 decoder
//   state_t  - arbiter FSM states
//   NUM_CH   - number of requesting channels
package rr_pkg;

    localparam int unsigned NUM_CH = 4;

    typedef logic [1:0] sel_t;

    typedef enum logic {
        IDLE  = 1'b0,
        GRANT = 1'b1
    } state_t;

endpackage

// File: rtl/rr_pick4.sv
// rr_pick4: combinational round-robin picker.
//   req [3:0]  in   request per channel
//   ptr [1:0]  in   channel with the highest priority this round
//   idx [1:0]  out  first requesting channel scanning ptr, ptr+1, ... (mod 4)
//   any        out  1 when at least one request is present
module rr_pick4
    import rr_pkg::*;
(
    input  logic [NUM_CH-1:0] req,
    input  sel_t              ptr,
    output sel_t              idx,
    output logic              any
);

    sel_t cand;

    always_comb begin
        idx  = ptr;
        any  = 1'b0;
        cand = '0;
        for (int unsigned k = 0; k < NUM_CH; k++) begin
            // 2-bit addition wraps naturally, giving the modulo-4 scan
            cand = ptr + 2'(k);
            if (!any && req[cand]) begin
                idx = cand;
                any = 1'b1;
            end
        end
    end

endmodule

// File: rtl/rr_select_2bit.sv
// rr_select_2bit: 4-channel round-robin arbiter producing the 2-bit select {a1,a0}
// for a downstream 2-to-4 decoder; gnt_valid qualifies the decoder outputs.
//   clk        in   rising-edge clock
//   rst        in   synchronous active-high reset
//   req  [3:0] in   level request per channel
//   done       in   1-cycle pulse from the owner: transfer finished
//   a0, a1     out  registered select bits (sel[0], sel[1])
//   gnt_valid  out  1 while {a1,a0} names the current owner
//   timeout    out  1-cycle pulse when a grant was released by the hold timer
// Parameter TIMEOUT: max cycles a grant may be held (0 disables the timer).
module rr_select_2bit
    import rr_pkg::*;
#(
    parameter int unsigned TIMEOUT = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [NUM_CH-1:0] req,
    input  logic              done,
    output logic              a0,
    output logic              a1,
    output logic              gnt_valid,
    output logic              timeout
);

    localparam int unsigned CNT_W = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT + 1);
    localparam logic [CNT_W-1:0] TO_LAST  = (TIMEOUT == 0) ? '0 : CNT_W'(TIMEOUT - 1);
    localparam logic [CNT_W-1:0] HOLD_MAX = '1;

    state_t           state,    state_n;
    sel_t             sel,      sel_n;
    sel_t             ptr,      ptr_n;
    logic [CNT_W-1:0] hold_cnt, hold_n;
    logic             valid_n;
    logic             to_n;

    sel_t             pick_idx;
    logic             pick_any;
    logic             withdrew;
    logic             to_hit;

    rr_pick4 u_pick (
        .req (req),
        .ptr (ptr),
        .idx (pick_idx),
        .any (pick_any)
    );

    assign withdrew = !req[sel];
    assign to_hit   = (TIMEOUT != 0) && (hold_cnt == TO_LAST);

    always_comb begin
        state_n = state;
        sel_n   = sel;
        ptr_n   = ptr;
        hold_n  = hold_cnt;
        valid_n = gnt_valid;
        to_n    = 1'b0;
        unique case (state)
            IDLE: begin
                // done is ignored here; only a request can start a grant
                if (pick_any) begin
                    sel_n   = pick_idx;
                    valid_n = 1'b1;
                    hold_n  = '0;
                    state_n = GRANT;
                end
            end
            GRANT: begin
                if (done || withdrew || to_hit) begin
                    state_n = IDLE;
                    valid_n = 1'b0;
                    ptr_n   = sel + 2'd1;
                    // timeout is reported only when the timer alone caused the release
                    to_n    = to_hit && !done && !withdrew;
                end else if (hold_cnt != HOLD_MAX) begin
                    hold_n = hold_cnt + 1'b1;
                end
            end
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            sel       <= '0;
            ptr       <= '0;
            hold_cnt  <= '0;
            gnt_valid <= 1'b0;
            timeout   <= 1'b0;
        end else begin
            state     <= state_n;
            sel       <= sel_n;
            ptr       <= ptr_n;
            hold_cnt  <= hold_n;
            gnt_valid <= valid_n;
            timeout   <= to_n;
        end
    end

    assign a0 = sel[0];
    assign a1 = sel[1];

endmodule

// File: tb/tb_rr_select_2bit.sv
module tb_rr_select_2bit;

    localparam int TO = 16;

    logic       clk  = 1'b0;
    logic       rst  = 1'b1;
    logic       done = 1'b0;
    logic [3:0] req  = 4'b0000;
    logic       a0, a1, gnt_valid, timeout;

    int n_cmp = 0;
    int n_bad = 0;
    bit armed = 1'b0;

    always #5 clk = ~clk;

    rr_select_2bit #(.TIMEOUT(TO)) dut (
        .clk       (clk),
        .rst       (rst),
        .req       (req),
        .done      (done),
        .a0        (a0),
        .a1        (a1),
        .gnt_valid (gnt_valid),
        .timeout   (timeout)
    );

    // downstream 2-to-4 decoder gated by gnt_valid
    logic [3:0] dec, en;
    always_comb begin
        case ({a1, a0})
            2'b00:   dec = 4'b0001;
            2'b01:   dec = 4'b0010;
            2'b10:   dec = 4'b0100;
            2'b11:   dec = 4'b1000;
            default: dec = 4'b0000;
        endcase
        en = gnt_valid ? dec : 4'b0000;
    end

    task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // reference: owner chosen as first requester in rotating order from ptr
    logic m_valid = 1'b0;
    logic m_to    = 1'b0;
    int   m_sel   = 0;
    int   m_ptr   = 0;
    int   m_hold  = 0;

    function automatic int first_req(input logic [3:0] r, input int p);
        for (int k = 0; k < 4; k++)
            if (r[(p + k) % 4]) return (p + k) % 4;
        return -1;
    endfunction

    always @(posedge clk) begin
        if (rst) begin
            m_valid <= 1'b0; m_to <= 1'b0; m_sel <= 0; m_ptr <= 0; m_hold <= 0;
        end else if (!m_valid) begin
            m_to <= 1'b0;
            if (first_req(req, m_ptr) >= 0) begin
                m_sel   <= first_req(req, m_ptr);
                m_valid <= 1'b1;
                m_hold  <= 0;
            end
        end else if (done || !req[m_sel] || (m_hold == TO - 1)) begin
            m_valid <= 1'b0;
            m_ptr   <= (m_sel + 1) % 4;
            m_to    <= !done && req[m_sel];
        end else begin
            m_hold <= m_hold + 1;
            m_to   <= 1'b0;
        end
    end

    always @(negedge clk) begin
        logic [7:0] exp_en;
        if (armed) begin
            check("valid",   {7'd0, gnt_valid}, {7'd0, m_valid});
            check("sel",     {6'd0, a1, a0},    8'(m_sel));
            check("timeout", {7'd0, timeout},   {7'd0, m_to});
            if (gnt_valid) begin
                exp_en = 8'd1 << m_sel;
                check("dec_onehot", {4'd0, en}, exp_en);
            end
            check("dec_excl", 8'($countones(en) <= 1), 8'd1);
        end
    end

    int order [5] = '{0, 1, 2, 3, 0};
    int n;

    initial begin
        // reset with all requests held
        rst = 1'b1; req = 4'b1111;
        @(posedge clk);
        @(negedge clk);
        armed = 1'b1;
        check("t1_rst_valid", {7'd0, gnt_valid}, 8'd0);
        check("t1_rst_sel",   {6'd0, a1, a0},    8'd0);
        @(negedge clk);
        check("t1_rst_valid2", {7'd0, gnt_valid}, 8'd0);
        rst = 1'b0;
        @(negedge clk);
        check("t1_grant_valid", {7'd0, gnt_valid}, 8'd1);
        check("t1_grant_sel",   {6'd0, a1, a0},    8'd0);

        // full rotation with done at the end of every grant
        for (int g = 0; g < 5; g++) begin
            if (g > 0) begin
                @(negedge clk);
                check("t2_valid", {7'd0, gnt_valid}, 8'd1);
                check("t2_order", {6'd0, a1, a0},    8'(order[g]));
            end
            done = 1'b1;
            @(negedge clk);
            done = 1'b0;
            check("t2_dead", {7'd0, gnt_valid}, 8'd0);
        end

        // single requester ch2, then withdrawal leaves ptr=3
        req = 4'b0100;
        @(negedge clk);
        check("t3_grant_sel", {6'd0, a1, a0}, 8'd2);
        req = 4'b0000;
        @(negedge clk);
        check("t3_withdraw", {7'd0, gnt_valid}, 8'd0);
        req = 4'b1001;
        @(negedge clk);
        check("t3_ptr3_sel", {6'd0, a1, a0}, 8'd3);

        // timeout on a held ch1 grant
        done = 1'b1; req = 4'b0010;
        @(negedge clk);
        done = 1'b0;
        check("t4_dead", {7'd0, gnt_valid}, 8'd0);
        @(negedge clk);
        check("t4_grant_sel", {6'd0, a1, a0}, 8'd1);
        n = 0;
        while (gnt_valid === 1'b1 && n < 40) begin
            n++;
            @(negedge clk);
        end
        check("t4_hold_len",      8'(n),             8'd16);
        check("t4_timeout_pulse", {7'd0, timeout},   8'd1);
        @(negedge clk);
        check("t4_regrant_sel",   {6'd0, a1, a0},    8'd1);
        check("t4_timeout_clear", {7'd0, timeout},   8'd0);

        // done coincides with the timeout edge
        repeat (15) @(negedge clk);
        done = 1'b1;
        @(negedge clk);
        done = 1'b0;
        check("t5_release", {7'd0, gnt_valid}, 8'd0);
        check("t5_no_to",   {7'd0, timeout},   8'd0);
        req = 4'b0110;
        @(negedge clk);
        check("t5_ptr_adv", {6'd0, a1, a0}, 8'd2);

        // reset in the middle of a ch3 grant
        done = 1'b1; req = 4'b1000;
        @(negedge clk);
        done = 1'b0;
        @(negedge clk);
        check("t6_grant_sel", {6'd0, a1, a0}, 8'd3);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("t6_rst_valid", {7'd0, gnt_valid}, 8'd0);
        check("t6_rst_sel",   {6'd0, a1, a0},    8'd0);
        @(negedge clk);
        check("t6_regrant",   {6'd0, a1, a0},    8'd3);

        // randomized traffic against the reference
        repeat (3000) begin
            if ($urandom_range(0, 19) == 0) req = 4'($urandom_range(0, 15));
            done = ($urandom_range(0, 24) == 0);
            rst  = ($urandom_range(0, 299) == 0);
            @(negedge clk);
        end
        rst = 1'b0; done = 1'b0;
        @(negedge clk);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
